hdlc_rx_ctrl: RTL and testbench
===============================

# hdlc_rx_ctrl

Frame-level controller for the HDLC receive path. It consumes the bit-level events of the Rx channel (flag, abort, destuffed byte, FCS result) and sequences frame reception. It drives the Rx buffer write port and the byte-read side, and owns the Rx status/control bits (ValidFrame, Ready, Overflow, AbortSignal, FrameError, EoF, FrameSize) that the CPU register interface exposes.

## Interface
- MAX_BYTES, 128: Rx buffer depth in bytes; ADDR_W = $clog2(MAX_BYTES).
- MIN_BYTES, 1: minimum payload bytes, excluding FCS, for a non-error frame.
- Clk  in  1  system clock, all logic on posedge.
- Rst  in  1  reset, asynchronous, active-high.
- Rx_FlagDetect  in  1  1-cycle pulse: 01111110 received.
- Rx_AbortDetect  in  1  1-cycle pulse: seven consecutive ones received.
- Rx_NewByte  in  1  1-cycle pulse: destuffed byte on Rx_Data.
- Rx_Data  in  8  byte qualified by Rx_NewByte.
- Rx_FCSerr  in  1  FCS mismatch; sampled only with the closing Rx_FlagDetect.
- Rx_FCSen  in  1  config: last 2 frame bytes are FCS.
- Rx_Drop  in  1  CPU pulse: discard held frame.
- Rx_RdBuff  in  1  CPU pulse: read one byte of held frame.
- Rx_ValidFrame  out  1  frame in progress.
- Rx_WrBuff  out  1  buffer write strobe.
- Rx_WrAddr  out  ADDR_W  write address.
- Rx_WrData  out  8  write data.
- Rx_RdAddr  out  ADDR_W  read address for next Rx_RdBuff.
- Rx_FrameSize  out  ADDR_W+1  payload length of held frame.
- Rx_Ready, Rx_Overflow, Rx_AbortSignal, Rx_FrameError  out  1 each  frame status.
- Rx_EoF  out  1  1-cycle pulse: frame ended (any outcome).

## Operation
- States: IDLE (hunt), OPEN (flag seen, no data), FRAME (receiving), HOLD (good frame awaiting CPU).
- IDLE: FlagDetect -> OPEN. All else ignored.
- OPEN: FlagDetect -> OPEN (idle flags). AbortDetect -> IDLE with no status. NewByte -> FRAME. First NewByte clears Overflow/AbortSignal/FrameError/FrameSize, sets ValidFrame, writes at address 0, count=1.
- FRAME, NewByte: if count<MAX_BYTES, write at address count and count++. Otherwise set internal ovf and suppress the write. count saturates at MAX_BYTES.
- FRAME, AbortDetect: ValidFrame=0, AbortSignal=1, EoF pulse -> IDLE.
- FRAME, FlagDetect (close): ValidFrame=0, EoF pulse. Outcome priority:
  - ovf: Overflow=1, FrameSize=MAX_BYTES -> OPEN.
  - else if count-2*Rx_FCSen < MIN_BYTES, or (Rx_FCSen and Rx_FCSerr): FrameError=1 -> OPEN.
  - else: Ready=1, FrameSize=count-2*Rx_FCSen -> HOLD.
- Exactly one of Ready/Overflow/AbortSignal/FrameError is set at each EoF. The first three are mutually exclusive at all times.
- HOLD: Flag, Abort and NewByte are ignored. Rx_RdBuff increments the read address (Rx_RdAddr starts at 0). When the read of address FrameSize-1 occurs: Ready=0, RdAddr=0 -> IDLE. Rx_Drop: Ready=0, RdAddr=0 -> IDLE.
- Rx_Drop/Rx_RdBuff outside HOLD: ignored.
- Status bits are sticky until the first byte of the next frame, except Ready, which clears as above.

## Timing
- All outputs are registered. Reset value of every output is 0; state IDLE; count 0.
- Write latency: WrBuff/WrAddr/WrData are valid the cycle after NewByte, one cycle wide.
- ValidFrame rises the cycle after the first NewByte after a flag.
- Status bits, FrameSize, EoF and the ValidFrame fall are all valid the cycle after the closing FlagDetect/AbortDetect.
- Simultaneous events:
  - Abort+Flag same cycle: abort wins.
  - NewByte+Flag in FRAME: byte counted and written first, then the frame closes.
  - NewByte+Abort: byte discarded.
  - Drop+RdBuff in HOLD: Drop wins.
- Rst mid-frame: immediate return to IDLE, no EoF, no write.
- Width: count is ADDR_W+1 bits. The FCS subtraction uses the same width. A count below 2 with FCSen=1 is a FrameError without wrap.

## Structure
- hdlc_pkg: enum rx_ctrl_state_t {IDLE, OPEN, FRAME, HOLD}; localparam FCS_BYTES=2.
- Sub-module hdlc_rx_bytecnt: saturating counter with clear/inc/full, used for both the write count and the read address.

## Test plan
- Flag, 5 bytes (3 payload + 2 FCS), flag, FCSen=1, FCSerr=0 -> 5 writes at addresses 0..4; EoF with Ready=1, FrameSize=3. Then 3 RdBuff -> RdAddr 0,1,2; Ready=0 after the third.
- Same frame with FCSerr=1 -> FrameError=1, Ready=0, EoF once, state OPEN.
- Flag, 130 bytes, flag, MAX_BYTES=128 -> 128 writes only; Overflow=1, FrameSize=128, Ready=0.
- Flag, 4 bytes, AbortDetect -> AbortSignal=1, ValidFrame falls, EoF one cycle. Next flag plus byte clears AbortSignal.
- HOLD with FrameSize=10, 2 reads, then Drop -> Ready=0, RdAddr=0; a new frame is then accepted.
- Rst asserted mid-frame after 3 bytes -> all outputs 0 asynchronously. No EoF; subsequent flag+byte writes at address 0.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive frame controller.
package hdlc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    FRAME = 2'd2,
    HOLD  = 2'd3
  } rx_ctrl_state_t;

  localparam int FCS_BYTES = 2;

endpackage

// File: rtl/hdlc_rx_bytecnt.sv
// Saturating byte counter with synchronous clear and increment.
// Clear and increment together load one, so a fresh frame's first byte costs no extra cycle.
module hdlc_rx_bytecnt #(
  parameter int W    = 8,
  parameter int MAXV = 128
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_full
);

  localparam logic [W-1:0] MAX_W = W'(MAXV);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_base;
  logic         w_step;

  assign w_base = i_clr ? '0 : r_cnt;
  assign w_step = i_inc && (w_base != MAX_W);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_step) begin
      r_cnt <= w_base + {{(W-1){1'b0}}, w_step};
    end
  end

  assign o_cnt  = r_cnt;
  assign o_full = (r_cnt == MAX_W);

endmodule

// File: rtl/hdlc_rx_ctrl.sv
// HDLC receive frame sequencer: hunts flags, writes bytes to the Rx buffer,
// resolves the frame outcome and serves CPU reads of a held good frame.
module hdlc_rx_ctrl
  import hdlc_pkg::*;
#(
  parameter  int MAX_BYTES = 128,
  parameter  int MIN_BYTES = 1,
  localparam int ADDR_W    = $clog2(MAX_BYTES)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx_FlagDetect,
  input  logic              Rx_AbortDetect,
  input  logic              Rx_NewByte,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_FCSerr,
  input  logic              Rx_FCSen,
  input  logic              Rx_Drop,
  input  logic              Rx_RdBuff,
  output logic              Rx_ValidFrame,
  output logic              Rx_WrBuff,
  output logic [ADDR_W-1:0] Rx_WrAddr,
  output logic [7:0]        Rx_WrData,
  output logic [ADDR_W-1:0] Rx_RdAddr,
  output logic [ADDR_W:0]   Rx_FrameSize,
  output logic              Rx_Ready,
  output logic              Rx_Overflow,
  output logic              Rx_AbortSignal,
  output logic              Rx_FrameError,
  output logic              Rx_EoF
);

  localparam int                CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  MAX_W = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0]  MIN_W = CNT_W'(MIN_BYTES);
  localparam logic [CNT_W-1:0]  FCS_W = CNT_W'(FCS_BYTES);
  localparam logic [CNT_W-1:0]  ONE_W = CNT_W'(1);

  rx_ctrl_state_t    r_state;
  logic              r_valid;
  logic              r_wr_buff;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [CNT_W-1:0]  r_frame_size;
  logic              r_ready;
  logic              r_overflow;
  logic              r_abort;
  logic              r_frame_err;
  logic              r_eof;
  logic              r_ovf;

  logic [CNT_W-1:0]  w_wr_cnt;
  logic              w_wr_full;
  logic [CNT_W-1:0]  w_rd_cnt;
  logic              w_rd_full;
  logic              w_wr_clr;
  logic              w_wr_inc;
  logic              w_rd_clr;
  logic              w_rd_inc;
  logic              w_byte_acc;
  logic [CNT_W-1:0]  w_cnt_eff;
  logic [CNT_W-1:0]  w_fcs_sub;
  logic [CNT_W-1:0]  w_payload;
  logic              w_short;
  logic              w_ovf_eff;
  logic              w_last_rd;

  hdlc_rx_bytecnt #(.W(CNT_W), .MAXV(MAX_BYTES)) u_wr_cnt (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_clr  (w_wr_clr),
    .i_inc  (w_wr_inc),
    .o_cnt  (w_wr_cnt),
    .o_full (w_wr_full)
  );

  hdlc_rx_bytecnt #(.W(CNT_W), .MAXV(MAX_BYTES)) u_rd_cnt (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_clr  (w_rd_clr),
    .i_inc  (w_rd_inc),
    .o_cnt  (w_rd_cnt),
    .o_full (w_rd_full)
  );

  // A byte arriving with the closing flag counts toward the frame being closed.
  assign w_byte_acc = Rx_NewByte && !w_wr_full;
  assign w_cnt_eff  = w_wr_cnt + {{(CNT_W-1){1'b0}}, w_byte_acc};
  assign w_ovf_eff  = r_ovf || (Rx_NewByte && w_wr_full);
  assign w_fcs_sub  = Rx_FCSen ? FCS_W : '0;
  assign w_payload  = w_cnt_eff - w_fcs_sub;
  // The explicit under-FCS test keeps a wrapped subtraction from looking long.
  assign w_short    = (Rx_FCSen && (w_cnt_eff < FCS_W)) || (w_payload < MIN_W);
  assign w_last_rd  = (w_rd_cnt == (r_frame_size - ONE_W)) || w_rd_full;

  always_comb begin
    w_wr_clr = 1'b0;
    w_wr_inc = 1'b0;
    w_rd_clr = 1'b0;
    w_rd_inc = 1'b0;
    case (r_state)
      OPEN: begin
        w_wr_clr = Rx_NewByte && !Rx_AbortDetect;
        w_wr_inc = Rx_NewByte && !Rx_AbortDetect;
      end
      FRAME: begin
        w_wr_inc = w_byte_acc && !Rx_AbortDetect;
      end
      HOLD: begin
        w_rd_clr = Rx_Drop || (Rx_RdBuff && w_last_rd);
        w_rd_inc = Rx_RdBuff && !Rx_Drop && !w_last_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_valid      <= 1'b0;
      r_wr_buff    <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_size <= '0;
      r_ready      <= 1'b0;
      r_overflow   <= 1'b0;
      r_abort      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_eof        <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_wr_buff <= 1'b0;
      r_eof     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Rx_FlagDetect && !Rx_AbortDetect) r_state <= OPEN;
        end
        OPEN: begin
          if (Rx_AbortDetect) begin
            r_state <= IDLE;
          end else if (Rx_NewByte) begin
            r_wr_buff    <= 1'b1;
            r_wr_addr    <= '0;
            r_wr_data    <= Rx_Data;
            r_valid      <= 1'b1;
            r_overflow   <= 1'b0;
            r_abort      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_size <= '0;
            r_ovf        <= 1'b0;
            r_state      <= FRAME;
          end
        end
        FRAME: begin
          if (Rx_AbortDetect) begin
            r_valid <= 1'b0;
            r_abort <= 1'b1;
            r_eof   <= 1'b1;
            r_state <= IDLE;
          end else begin
            if (Rx_NewByte) begin
              if (!w_wr_full) begin
                r_wr_buff <= 1'b1;
                r_wr_addr <= w_wr_cnt[ADDR_W-1:0];
                r_wr_data <= Rx_Data;
              end else begin
                r_ovf <= 1'b1;
              end
            end
            if (Rx_FlagDetect) begin
              r_valid <= 1'b0;
              r_eof   <= 1'b1;
              if (w_ovf_eff) begin
                r_overflow   <= 1'b1;
                r_frame_size <= MAX_W;
                r_state      <= OPEN;
              end else if (w_short || (Rx_FCSen && Rx_FCSerr)) begin
                r_frame_err <= 1'b1;
                r_state     <= OPEN;
              end else begin
                r_ready      <= 1'b1;
                r_frame_size <= w_payload;
                r_state      <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (Rx_Drop || (Rx_RdBuff && w_last_rd)) begin
            r_ready <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Rx_ValidFrame  = r_valid;
  assign Rx_WrBuff      = r_wr_buff;
  assign Rx_WrAddr      = r_wr_addr;
  assign Rx_WrData      = r_wr_data;
  assign Rx_RdAddr      = w_rd_cnt[ADDR_W-1:0];
  assign Rx_FrameSize   = r_frame_size;
  assign Rx_Ready       = r_ready;
  assign Rx_Overflow    = r_overflow;
  assign Rx_AbortSignal = r_abort;
  assign Rx_FrameError  = r_frame_err;
  assign Rx_EoF         = r_eof;

endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// Directed bench for hdlc_rx_ctrl: vector table for the FCS frame flow plus
// hand-written sequences for overflow, abort, drop and reset mid-frame.
module tb_hdlc_rx_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx_FlagDetect = 1'b0;
  logic       Rx_AbortDetect = 1'b0;
  logic       Rx_NewByte = 1'b0;
  logic [7:0] Rx_Data = 8'h00;
  logic       Rx_FCSerr = 1'b0;
  logic       Rx_FCSen = 1'b1;
  logic       Rx_Drop = 1'b0;
  logic       Rx_RdBuff = 1'b0;
  logic       Rx_ValidFrame, Rx_WrBuff, Rx_Ready, Rx_Overflow;
  logic       Rx_AbortSignal, Rx_FrameError, Rx_EoF;
  logic [6:0] Rx_WrAddr, Rx_RdAddr;
  logic [7:0] Rx_WrData, Rx_FrameSize;

  int n_cmp = 0;
  int n_err = 0;

  hdlc_rx_ctrl #(.MAX_BYTES(128), .MIN_BYTES(1)) dut (
    .Clk(Clk), .Rst(Rst),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data), .Rx_FCSerr(Rx_FCSerr),
    .Rx_FCSen(Rx_FCSen), .Rx_Drop(Rx_Drop), .Rx_RdBuff(Rx_RdBuff),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_WrBuff(Rx_WrBuff), .Rx_WrAddr(Rx_WrAddr),
    .Rx_WrData(Rx_WrData), .Rx_RdAddr(Rx_RdAddr), .Rx_FrameSize(Rx_FrameSize),
    .Rx_Ready(Rx_Ready), .Rx_Overflow(Rx_Overflow), .Rx_AbortSignal(Rx_AbortSignal),
    .Rx_FrameError(Rx_FrameError), .Rx_EoF(Rx_EoF)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       fl, ab, nb;
    logic [7:0] d;
    logic       fe, dr, rd;
    logic       wr;
    logic [6:0] wa;
    logic [7:0] wd;
    logic       vf, rdy, ovf, abt, ferr, eof;
    logic [6:0] ra;
    logic [7:0] fs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int fl, ab, nb, d, fe, dr, rd,
                              input int wr, wa, wd, vf, rdy, ovf, abt, ferr, eof, ra, fs);
    vec_t v;
    v.fl = fl[0]; v.ab = ab[0]; v.nb = nb[0]; v.d = d[7:0];
    v.fe = fe[0]; v.dr = dr[0]; v.rd = rd[0];
    v.wr = wr[0]; v.wa = wa[6:0]; v.wd = wd[7:0];
    v.vf = vf[0]; v.rdy = rdy[0]; v.ovf = ovf[0]; v.abt = abt[0];
    v.ferr = ferr[0]; v.eof = eof[0]; v.ra = ra[6:0]; v.fs = fs[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic fl, ab, nb, input logic [7:0] d, input logic fe, dr, rd);
    Rx_FlagDetect = fl; Rx_AbortDetect = ab; Rx_NewByte = nb; Rx_Data = d;
    Rx_FCSerr = fe; Rx_Drop = dr; Rx_RdBuff = rd;
    @(posedge Clk);
    #1;
    Rx_FlagDetect = 1'b0; Rx_AbortDetect = 1'b0; Rx_NewByte = 1'b0;
    Rx_FCSerr = 1'b0; Rx_Drop = 1'b0; Rx_RdBuff = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_ValidFrame, Rx_Ready, Rx_Overflow,
                Rx_AbortSignal, Rx_FrameError, Rx_EoF, Rx_RdAddr, Rx_FrameSize});
  endfunction

  initial begin
    int nwr;
    logic [6:0] last_wa;
    logic [63:0] act, exp;

    // FCSen=1 frame flow: good frame, reads, FCS error, short frames, ignored CPU pulses
    tbl.push_back(mk(0,0,0,0,    0,0,0, 0,0,0,     0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,0,    0,0,0, 0,0,0,     0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,0,    0,0,0, 0,0,0,     0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,'hA1, 0,0,0, 1,0,'hA1,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,'hB2, 0,0,0, 1,1,'hB2,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,'hC3, 0,0,0, 1,2,'hC3,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,'hD4, 0,0,0, 1,3,'hD4,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,'hE5, 0,0,0, 1,4,'hE5,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,0,    0,0,0, 0,0,0,     0,1,0,0,0,1, 0,3));
    tbl.push_back(mk(0,0,0,0,    0,0,0, 0,0,0,     0,1,0,0,0,0, 0,3));
    tbl.push_back(mk(1,0,0,0,    0,0,0, 0,0,0,     0,1,0,0,0,0, 0,3));
    tbl.push_back(mk(0,0,0,0,    0,0,1, 0,0,0,     0,1,0,0,0,0, 1,3));
    tbl.push_back(mk(0,0,0,0,    0,0,1, 0,0,0,     0,1,0,0,0,0, 2,3));
    tbl.push_back(mk(0,0,0,0,    0,0,1, 0,0,0,     0,0,0,0,0,0, 0,3));
    tbl.push_back(mk(1,0,0,0,    0,0,0, 0,0,0,     0,0,0,0,0,0, 0,3));
    tbl.push_back(mk(0,0,1,'h11, 0,0,0, 1,0,'h11,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,'h22, 0,0,0, 1,1,'h22,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,'h33, 0,0,0, 1,2,'h33,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,'h44, 0,0,0, 1,3,'h44,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,1,'h55, 0,0,0, 1,4,'h55,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,0,    1,0,0, 0,0,0,     0,0,0,0,1,1, 0,0));
    tbl.push_back(mk(0,0,0,0,    0,0,0, 0,0,0,     0,0,0,0,1,0, 0,0));
    tbl.push_back(mk(0,0,1,'h66, 0,0,0, 1,0,'h66,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,1,'h77, 0,0,0, 1,1,'h77,  0,0,0,0,1,1, 0,0));
    tbl.push_back(mk(0,0,1,'h88, 0,0,0, 1,0,'h88,  1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,0,    0,0,0, 0,0,0,     0,0,0,0,1,1, 0,0));
    tbl.push_back(mk(0,0,0,0,    0,1,1, 0,0,0,     0,0,0,0,1,0, 0,0));

    repeat (2) @(posedge Clk);
    #1;
    chk("reset_in_progress", all_outs(), 64'd0);
    Rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].ab, tbl[i].nb, tbl[i].d, tbl[i].fe, tbl[i].dr, tbl[i].rd);
      act = 64'({Rx_WrBuff, tbl[i].wr ? Rx_WrAddr : 7'd0, tbl[i].wr ? Rx_WrData : 8'd0,
                 Rx_ValidFrame, Rx_Ready, Rx_Overflow, Rx_AbortSignal, Rx_FrameError,
                 Rx_EoF, Rx_RdAddr, Rx_FrameSize});
      exp = 64'({tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].vf, tbl[i].rdy, tbl[i].ovf,
                 tbl[i].abt, tbl[i].ferr, tbl[i].eof, tbl[i].ra, tbl[i].fs});
      chk($sformatf("vec%0d", i), act, exp);
    end

    // Overflow: 130 bytes into a 128-byte buffer (state is OPEN here)
    Rx_FCSen = 1'b0;
    nwr = 0;
    last_wa = 7'd0;
    step(1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 130; i++) begin
      step(0, 0, 1, 8'(i), 0, 0, 0);
      if (Rx_WrBuff) begin
        nwr++;
        last_wa = Rx_WrAddr;
      end
    end
    chk("ovf_write_count", 64'(nwr), 64'd128);
    chk("ovf_last_addr", 64'(last_wa), 64'd127);
    step(1, 0, 0, 8'h00, 0, 0, 0);
    chk("ovf_close", 64'({Rx_ValidFrame, Rx_Ready, Rx_Overflow, Rx_AbortSignal,
                          Rx_FrameError, Rx_EoF, Rx_FrameSize}),
        64'({6'b001001, 8'd128}));
    step(0, 0, 0, 8'h00, 0, 0, 0);
    chk("ovf_eof_single", 64'({Rx_EoF, Rx_Overflow}), 64'b01);

    // Abort with flag and byte in the same cycle: abort wins, byte dropped
    step(1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h40 + i), 0, 0, 0);
    chk("abort_pre_valid", 64'({Rx_ValidFrame, Rx_Overflow}), 64'b10);
    step(1, 1, 1, 8'hEE, 0, 0, 0);
    chk("abort_close", 64'({Rx_WrBuff, Rx_ValidFrame, Rx_Ready, Rx_Overflow,
                            Rx_AbortSignal, Rx_FrameError, Rx_EoF}), 64'b0000101);
    step(0, 0, 0, 8'h00, 0, 0, 0);
    chk("abort_eof_single", 64'({Rx_EoF, Rx_AbortSignal}), 64'b01);
    step(0, 0, 1, 8'h99, 0, 0, 0);
    chk("abort_idle_ignores_byte", 64'({Rx_WrBuff, Rx_ValidFrame}), 64'b00);
    step(1, 0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 1, 8'h5A, 0, 0, 0);
    chk("abort_cleared_next", 64'({Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_ValidFrame,
                                   Rx_AbortSignal}), 64'({1'b1, 7'd0, 8'h5A, 2'b10}));

    // HOLD with 10 bytes, two reads, then Drop together with RdBuff
    for (int i = 1; i < 10; i++) step(0, 0, 1, 8'(i), 0, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0, 0);
    chk("hold_ready", 64'({Rx_Ready, Rx_FrameSize, Rx_EoF}), 64'({1'b1, 8'd10, 1'b1}));
    step(0, 0, 0, 8'h00, 0, 0, 1);
    step(0, 0, 0, 8'h00, 0, 0, 1);
    chk("hold_two_reads", 64'({Rx_Ready, Rx_RdAddr}), 64'({1'b1, 7'd2}));
    step(0, 0, 0, 8'h00, 0, 1, 1);
    chk("hold_drop", 64'({Rx_Ready, Rx_RdAddr, Rx_FrameSize}), 64'({1'b0, 7'd0, 8'd10}));
    step(1, 0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 1, 8'hC7, 0, 0, 0);
    chk("hold_new_frame", 64'({Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_ValidFrame}),
        64'({1'b1, 7'd0, 8'hC7, 1'b1}));

    // Asynchronous reset in the middle of a frame after 3 bytes
    step(0, 0, 1, 8'hC8, 0, 0, 0);
    step(0, 0, 1, 8'hC9, 0, 0, 0);
    chk("rst_pre_valid", 64'({Rx_ValidFrame, Rx_WrAddr}), 64'({1'b1, 7'd2}));
    #2;
    Rst = 1'b1;
    #1;
    chk("rst_async_outputs", all_outs(), 64'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    step(0, 0, 0, 8'h00, 0, 0, 0);
    chk("rst_no_eof", all_outs(), 64'd0);
    step(1, 0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 1, 8'h3C, 0, 0, 0);
    chk("rst_restart_addr0", 64'({Rx_WrBuff, Rx_WrAddr, Rx_WrData, Rx_ValidFrame}),
        64'({1'b1, 7'd0, 8'h3C, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
